// File: rtl/offset_load_scheduler_pkg.sv
// Shared FSM encoding and default sizing for the offset URAM load scheduler.
package offset_load_scheduler_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam int unsigned DefHbmAwidth      = 28;
   localparam int unsigned DefBeatCntWidth   = 16;
   localparam int unsigned DefMaxOutstanding = 32;
   localparam int unsigned DefCredWidth      = 6;
   localparam int unsigned CoreNumWidth      = 3;
   // URAM beats each core owns within one pseudo channel.
   localparam int unsigned ChanBeatCount     = (1 << 15) >> CoreNumWidth;

endpackage

// File: rtl/hbm_credit_counter.sv
// Up/down outstanding-request counter; callers keep inc/dec within 0..MAX_COUNT.
module hbm_credit_counter #(
   parameter int unsigned MAX_COUNT = 32,
   parameter int unsigned CNT_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 dec,
   output logic [CNT_WIDTH-1:0] count_next,
   output logic                 at_limit,
   output logic                 is_zero
);

   logic [CNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !dec) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else if (dec && !inc) begin
         count_d = count_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_next = count_d;
   assign at_limit   = (count_q == CNT_WIDTH'(MAX_COUNT));
   assign is_zero    = (count_q == '0);

endmodule

// File: rtl/offset_load_scheduler.sv
// Issues a credit-limited HBM read burst that fills one pseudo channel's offset URAMs and
// holds the front end off until every beat has returned.
module offset_load_scheduler
   import offset_load_scheduler_pkg::*;
#(
   parameter int unsigned HBM_AWIDTH      = DefHbmAwidth,
   parameter int unsigned BEAT_CNT_WIDTH  = DefBeatCntWidth,
   parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding,
   parameter int unsigned CRED_WIDTH      = DefCredWidth
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [HBM_AWIDTH-1:0]     base_addr,
   input  logic [BEAT_CNT_WIDTH-1:0] num_beats,
   input  logic                      hbm_controller_full,
   input  logic                      hbm_data_valid,
   output logic [HBM_AWIDTH-1:0]     hbm_controller_addr,
   output logic                      hbm_addr_valid,
   output logic                      load_done,
   output logic                      front_ready,
   output logic [BEAT_CNT_WIDTH-1:0] beats_received,
   output logic                      protocol_err
);

   state_e                    state_q, state_d;
   logic [HBM_AWIDTH-1:0]     addr_q, addr_d, base_q, base_d;
   logic [BEAT_CNT_WIDTH-1:0] num_q, num_d, issued_q, issued_d, recv_q, recv_d;
   logic                      valid_q, valid_d, done_q, done_d, perr_q, perr_d;

   logic                      accept, ret, cred_zero, cred_limit;
   logic [CRED_WIDTH-1:0]     cred_next;
   logic [BEAT_CNT_WIDTH-1:0] issued_after, recv_after;

   assign accept = valid_q && !hbm_controller_full;
   // A beat with nothing in flight is a protocol error, not a return.
   assign ret    = hbm_data_valid && !cred_zero;

   assign issued_after = issued_q + BEAT_CNT_WIDTH'(accept);
   assign recv_after   = recv_q + BEAT_CNT_WIDTH'(ret);

   hbm_credit_counter #(
      .MAX_COUNT (MAX_OUTSTANDING),
      .CNT_WIDTH (CRED_WIDTH)
   ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .inc        (accept),
      .dec        (ret),
      .count_next (cred_next),
      .at_limit   (cred_limit),
      .is_zero    (cred_zero)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      valid_d  = valid_q;
      base_d   = base_q;
      num_d    = num_q;
      issued_d = issued_after;
      recv_d   = recv_after;
      done_d   = done_q;
      perr_d   = perr_q | (hbm_data_valid && cred_zero);

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               base_d   = base_addr;
               num_d    = num_beats;
               addr_d   = base_addr;
               issued_d = '0;
               recv_d   = '0;
               if (num_beats == '0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
               end else begin
                  state_d = StIssue;
                  done_d  = 1'b0;
                  valid_d = 1'b1;
               end
            end
         end
         StIssue: begin
            // Unaccepted requests keep issued_after unchanged, so addr/valid hold.
            valid_d = (issued_after < num_q) && (cred_next < CRED_WIDTH'(MAX_OUTSTANDING));
            addr_d  = base_q + HBM_AWIDTH'(issued_after);
            if (accept && (issued_after == num_q)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            valid_d = 1'b0;
            if (recv_after == num_q) begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         valid_q  <= 1'b0;
         base_q   <= '0;
         num_q    <= '0;
         issued_q <= '0;
         recv_q   <= '0;
         done_q   <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         base_q   <= base_d;
         num_q    <= num_d;
         issued_q <= issued_d;
         recv_q   <= recv_d;
         done_q   <= done_d;
         perr_q   <= perr_d;
      end
   end

   // valid is only raised with credit to spare, so an accept can never land at the limit.
   credit_never_exceeded: assert property (@(posedge clk) disable iff (rst)
      !(accept && cred_limit));

   assign hbm_controller_addr = addr_q;
   assign hbm_addr_valid      = valid_q;
   assign load_done           = done_q;
   assign front_ready         = done_q;
   assign beats_received      = recv_q;
   assign protocol_err        = perr_q;

endmodule
